// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the multi-cycle MUL/DIVU/REMU sequencer: ALU op codes,
// sequencer op codes and FSM states.
package muldiv_seq_pkg;

   localparam logic [4:0] IADD = 5'h00;
   localparam logic [4:0] ISUB = 5'h01;
   localparam logic [4:0] IGEU = 5'h0b;

   localparam logic [1:0] MD_MUL  = 2'b00;
   localparam logic [1:0] MD_DIVU = 2'b01;
   localparam logic [1:0] MD_REMU = 2'b10;
   localparam logic [1:0] MD_RSV  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MUL     = 3'd1,
      S_DIV_CMP = 3'd2,
      S_DIV_SUB = 3'd3,
      S_DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Shift-add multiplier and restoring divider that borrow the shared ALU for
// every add, subtract and compare; one ALU op per cycle, fixed latency.
module muldiv_seq
   import muldiv_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_c,
   input  logic [31:0] alu_y
);

   state_t      state;
   logic [1:0]  op_q;
   logic [4:0]  cnt;
   logic [31:0] acc, mcand, mplier;
   logic [31:0] quo, rem, divisor;
   logic        ge_q;

   logic [31:0] sh;
   logic        ge;
   logic        last;

   assign sh   = {rem[30:0], quo[31]};
   // rem[31] set means the shifted value needs a 33rd bit, so it must exceed the divisor
   assign ge   = rem[31] | alu_y[0];
   assign last = (cnt == 5'd31);

   always_comb begin
      alu_a = '0;
      alu_b = '0;
      alu_c = IADD;
      case (state)
         S_MUL: begin
            alu_a = acc;
            alu_b = mplier[0] ? mcand : 32'd0;
         end
         S_DIV_CMP: begin
            alu_a = sh;
            alu_b = divisor;
            alu_c = IGEU;
         end
         S_DIV_SUB: begin
            alu_a = rem;
            alu_b = divisor;
            alu_c = ISUB;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         op_q    <= '0;
         cnt     <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         quo     <= '0;
         rem     <= '0;
         divisor <= '0;
         ge_q    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               op_q    <= op;
               cnt     <= '0;
               acc     <= '0;
               mcand   <= opa;
               mplier  <= opb;
               quo     <= opa;
               rem     <= '0;
               divisor <= opb;
               ge_q    <= 1'b0;
               busy    <= 1'b1;
               case (op)
                  MD_MUL:           state <= S_MUL;
                  MD_DIVU, MD_REMU: state <= S_DIV_CMP;
                  default: begin
                     state  <= S_DONE;
                     done   <= 1'b1;
                     result <= '0;
                  end
               endcase
            end
            S_MUL: begin
               acc    <= alu_y;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (last) begin
                  state  <= S_DONE;
                  done   <= 1'b1;
                  result <= alu_y;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            S_DIV_CMP: begin
               rem   <= sh;
               quo   <= {quo[30:0], ge};
               ge_q  <= ge;
               state <= S_DIV_SUB;
            end
            S_DIV_SUB: begin
               if (ge_q) rem <= alu_y;
               if (last) begin
                  state  <= S_DONE;
                  done   <= 1'b1;
                  result <= (op_q == MD_REMU) ? (ge_q ? alu_y : rem) : quo;
               end else begin
                  cnt   <= cnt + 5'd1;
                  state <= S_DIV_CMP;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural ALU attached to its ALU ports.
module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [1:0]  op;
   logic [31:0] opa, opb;
   logic        busy, done;
   logic [31:0] result, alu_a, alu_b, alu_y;
   logic [4:0]  alu_c;

   int passed = 0;
   int total  = 0;

   muldiv_seq dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
      .busy(busy), .done(done), .result(result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_y(alu_y)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_y = '0;
      case (alu_c)
         IADD:    alu_y = alu_a + alu_b;
         ISUB:    alu_y = alu_a - alu_b;
         IGEU:    alu_y = {31'd0, alu_a >= alu_b};
         default: alu_y = '0;
      endcase
   end

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, want %h", nm, act, exp);
   endtask

   // Issue one op and return the result and the cycle count from acceptance to done.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat);
      @(negedge clk);
      start = 1'b1; op = o; opa = a; opb = b;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      r   = '0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            r   = result;
            break;
         end
      end
   endtask

   initial begin
      logic [31:0] r;
      int          lat;
      int          bad;

      vecs[0] = '{"mul_7x6",     MD_MUL,  32'd7,        32'd6,        32'd42,         33};
      vecs[1] = '{"mul_ffxff",   MD_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   33};
      vecs[2] = '{"mul_ovf",     MD_MUL,  32'h00010000, 32'h00010000, 32'h00000000,   33};
      vecs[3] = '{"divu_100_7",  MD_DIVU, 32'd100,      32'd7,        32'd14,         65};
      vecs[4] = '{"remu_100_7",  MD_REMU, 32'd100,      32'd7,        32'd2,          65};
      vecs[5] = '{"divu_big",    MD_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'h00000001,   65};
      vecs[6] = '{"remu_big",    MD_REMU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE,   65};
      vecs[7] = '{"divu_by0",    MD_DIVU, 32'd1234,     32'd0,        32'hFFFFFFFF,   65};
      vecs[8] = '{"remu_by0",    MD_REMU, 32'd1234,     32'd0,        32'd1234,       65};
      vecs[9] = '{"rsv",         MD_RSV,  32'd55,       32'd66,       32'd0,           1};

      rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy",   {31'd0, busy}, 32'd0);
      check("rst_done",   {31'd0, done}, 32'd0);
      check("rst_result", result,        32'd0);
      check("rst_alu_a",  alu_a,         32'd0);
      check("rst_alu_b",  alu_b,         32'd0);
      check("rst_alu_c",  {27'd0, alu_c}, {27'd0, IADD});

      foreach (vecs[i]) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
         check({vecs[i].name, "_res"}, r, vecs[i].exp);
         check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
         @(negedge clk);
         check({vecs[i].name, "_idle"}, {31'd0, busy}, 32'd0);
      end

      // Reset in the middle of a divide.
      @(negedge clk);
      start = 1'b1; op = MD_DIVU; opa = 32'd1000; opb = 32'd3;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(negedge clk);
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("abort_busy",   {31'd0, busy},  32'd0);
      check("abort_done",   {31'd0, done},  32'd0);
      check("abort_result", result,         32'd0);
      check("abort_alu_c",  {27'd0, alu_c}, {27'd0, IADD});
      do_op(MD_MUL, 32'd3, 32'd5, r, lat);
      check("mul_3x5_res", r,   32'd15);
      check("mul_3x5_lat", lat, 33);

      // start held high through a whole MUL and past done.
      @(negedge clk);
      start = 1'b1; op = MD_MUL; opa = 32'd7; opb = 32'd6;
      lat = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (done) begin lat = i; break; end
      end
      check("held1_lat", lat,    33);
      check("held1_res", result, 32'd42);
      opa = 32'd2; opb = 32'd9;
      @(negedge clk);
      check("held_idle_busy", {31'd0, busy}, 32'd0);
      check("held_idle_res",  result,        32'd42);
      lat = 0;
      bad = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (done) begin lat = i; break; end
         if (result !== 32'd42) bad++;
      end
      start = 1'b0;
      check("held_hold_res", bad,    0);
      check("held2_lat",     lat,    33);
      check("held2_res",     result, 32'd18);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
